// File: rtl/iot_event_arbiter.sv
// Round-robin arbiter that turns gateway join/leave requests into single-cycle
// change/on_off events and keeps a shadow device count that never wraps.
module iot_event_arbiter #(
    parameter int N_REQ   = 4,
    parameter int CNT_W   = 8,
    parameter int MAX_DEV = 200
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en_i,
    input  logic             clr_i,
    input  logic [N_REQ-1:0] req_i,
    input  logic [N_REQ-1:0] dir_i,
    output logic [N_REQ-1:0] ack_o,
    output logic [N_REQ-1:0] nack_o,
    output logic             change_o,
    output logic             on_off_o,
    output logic [CNT_W-1:0] count_o,
    output logic             full_o,
    output logic             empty_o,
    output logic             state_o
);

    localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    // Handshake: a port holds req_i (with stable dir_i) until it sees a
    // one-cycle ack_o or nack_o pulse; it is masked from arbitration while
    // that pulse is visible, so it may drop req_i then or re-request later.

    state_t             state_q, state_d;
    logic [PTR_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [N_REQ-1:0]   ack_q, ack_d;
    logic [N_REQ-1:0]   nack_q, nack_d;
    logic               change_q, change_d;
    logic               on_off_q, on_off_d;

    logic [N_REQ-1:0]   elig;
    logic               grant_valid;
    logic [PTR_W-1:0]   grant_idx;
    logic               at_max;
    logic               at_zero;

    assign elig    = req_i & ~(ack_q | nack_q);
    assign at_max  = (count_q == CNT_W'(MAX_DEV));
    assign at_zero = (count_q == '0);

    // Scan downward in priority offset so the port closest to rr_ptr wins.
    always_comb begin
        grant_idx = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            int j;
            j = int'(rr_ptr_q) + i;
            if (j >= N_REQ) j = j - N_REQ;
            if (elig[j]) grant_idx = PTR_W'(j);
        end
    end

    assign grant_valid = en_i & ~clr_i & (|elig);

    always_comb begin
        state_d  = IDLE;
        rr_ptr_d = rr_ptr_q;
        count_d  = count_q;
        ack_d    = '0;
        nack_d   = '0;
        change_d = 1'b0;
        on_off_d = on_off_q;
        if (clr_i) begin
            count_d = '0;
        end else if (grant_valid) begin
            // GRANT is the response cycle; back-to-back grants stay in GRANT.
            state_d  = GRANT;
            rr_ptr_d = (grant_idx == PTR_W'(N_REQ - 1)) ? '0 : grant_idx + 1'b1;
            if ((dir_i[grant_idx] && at_max) || (!dir_i[grant_idx] && at_zero)) begin
                nack_d[grant_idx] = 1'b1;
            end else begin
                ack_d[grant_idx] = 1'b1;
                change_d         = 1'b1;
                on_off_d         = dir_i[grant_idx];
                count_d          = dir_i[grant_idx] ? count_q + 1'b1 : count_q - 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            rr_ptr_q <= '0;
            count_q  <= '0;
            ack_q    <= '0;
            nack_q   <= '0;
            change_q <= 1'b0;
            on_off_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            count_q  <= count_d;
            ack_q    <= ack_d;
            nack_q   <= nack_d;
            change_q <= change_d;
            on_off_q <= on_off_d;
        end
    end

    assign ack_o    = ack_q;
    assign nack_o   = nack_q;
    assign change_o = change_q;
    assign on_off_o = on_off_q;
    assign count_o  = count_q;
    assign full_o   = at_max;
    assign empty_o  = at_zero;
    assign state_o  = state_q;

endmodule

// File: tb/tb_iot_event_arbiter.sv
// Directed bench for iot_event_arbiter: a rule-level reference model checked
// every cycle, plus hand-computed literal expectations at key points.
module tb_iot_event_arbiter;

    localparam int N   = 4;
    localparam int W   = 8;
    localparam int MAX = 200;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         en  = 1'b0;
    logic         clr = 1'b0;
    logic [N-1:0] req = '0;
    logic [N-1:0] dir = '0;
    logic [N-1:0] ack, nack;
    logic         change, on_off, full, empty, state;
    logic [W-1:0] count;

    int checks   = 0;
    int failures = 0;
    bit auto_drop = 1'b1;
    bit cmp_en    = 1'b0;

    iot_event_arbiter #(.N_REQ(N), .CNT_W(W), .MAX_DEV(MAX)) dut (
        .clk      (clk),
        .rst      (rst),
        .en_i     (en),
        .clr_i    (clr),
        .req_i    (req),
        .dir_i    (dir),
        .ack_o    (ack),
        .nack_o   (nack),
        .change_o (change),
        .on_off_o (on_off),
        .count_o  (count),
        .full_o   (full),
        .empty_o  (empty),
        .state_o  (state)
    );

    always #5 clk = ~clk;

    // Reference model: the arbitration rules written directly as arithmetic.
    int           m_count;
    int           m_rr;
    logic [N-1:0] m_ack, m_nack;
    logic         m_change, m_on;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_count  <= 0;
            m_rr     <= 0;
            m_ack    <= '0;
            m_nack   <= '0;
            m_change <= 1'b0;
            m_on     <= 1'b0;
        end else begin
            logic [N-1:0] e;
            int g;
            e = req & ~(m_ack | m_nack);
            g = -1;
            m_ack    <= '0;
            m_nack   <= '0;
            m_change <= 1'b0;
            if (clr) begin
                m_count <= 0;
            end else if (en && e != '0) begin
                for (int k = 0; k < N; k++) begin
                    if (g < 0 && e[(m_rr + k) % N]) g = (m_rr + k) % N;
                end
                m_rr <= (g + 1) % N;
                if ((dir[g] && m_count == MAX) || (!dir[g] && m_count == 0)) begin
                    m_nack[g] <= 1'b1;
                end else begin
                    m_ack[g]  <= 1'b1;
                    m_change  <= 1'b1;
                    m_on      <= dir[g];
                    m_count   <= dir[g] ? m_count + 1 : m_count - 1;
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (cmp_en && !rst) begin
            chk("model_ack",    32'(ack),    32'(m_ack));
            chk("model_nack",   32'(nack),   32'(m_nack));
            chk("model_change", 32'(change), 32'(m_change));
            chk("model_count",  32'(count),  32'(m_count));
            chk("model_full",   32'(full),   32'(m_count == MAX));
            chk("model_empty",  32'(empty),  32'(m_count == 0));
            if (m_change) chk("model_on_off", 32'(on_off), 32'(m_on));
        end
    end

    task automatic step();
        @(negedge clk);
        if (auto_drop) req = req & ~(ack | nack);
    endtask

    task automatic do_req(input int p, input logic d);
        step();
        req[p] = 1'b1;
        dir[p] = d;
        step();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    initial begin
        int n;
        do_reset();
        cmp_en = 1'b1;
        en     = 1'b1;

        // Idle after reset
        for (int i = 0; i < 10; i++) begin
            step();
            chk("rst_count", 32'(count), 32'd0);
            chk("rst_empty", 32'(empty), 32'd1);
            chk("rst_full",  32'(full),  32'd0);
            chk("rst_pulse", 32'({ack, nack, change}), 32'd0);
        end

        // Single join on port 1
        do_req(1, 1'b1);
        chk("p1_ack",    32'(ack),    32'b0010);
        chk("p1_change", 32'(change), 32'd1);
        chk("p1_on_off", 32'(on_off), 32'd1);
        chk("p1_count",  32'(count),  32'd1);
        chk("p1_empty",  32'(empty),  32'd0);
        chk("p1_state",  32'(state),  32'd1);

        // All ports joining continuously from rr_ptr=0
        do_reset();
        auto_drop = 1'b0;
        req = 4'hF;
        dir = 4'hF;
        for (int i = 0; i < 8; i++) begin
            step();
            chk("rr_ack",   32'(ack),   32'(4'b0001 << (i % 4)));
            chk("rr_count", 32'(count), 32'(i + 1));
        end

        // Fill to capacity
        n = 0;
        while (m_count != MAX && n < 400) begin
            step();
            n++;
        end
        chk("fill_timeout", 32'(n < 400), 32'd1);
        req = '0;
        auto_drop = 1'b1;
        step();
        chk("fill_full",  32'(full),  32'd1);
        chk("fill_count", 32'(count), 32'd200);

        do_req(2, 1'b1);
        chk("cap_nack",   32'(nack),   32'b0100);
        chk("cap_change", 32'(change), 32'd0);
        chk("cap_count",  32'(count),  32'd200);
        chk("cap_full",   32'(full),   32'd1);
        do_req(2, 1'b0);
        chk("leave_ack",   32'(ack),    32'b0100);
        chk("leave_count", 32'(count),  32'd199);
        chk("leave_full",  32'(full),   32'd0);
        chk("leave_dir",   32'(on_off), 32'd0);

        // Clear, then leave at zero
        step();
        clr = 1'b1;
        step();
        clr = 1'b0;
        chk("clr_count", 32'(count), 32'd0);
        do_req(3, 1'b0);
        chk("zero_nack",   32'(nack),   32'b1000);
        chk("zero_change", 32'(change), 32'd0);
        chk("zero_count",  32'(count),  32'd0);

        // clr with joins pending: no pulse that cycle, joins served after
        step();
        req = 4'b0011;
        dir = 4'b0011;
        clr = 1'b1;
        step();
        chk("clrp_pulse", 32'({ack, nack, change}), 32'd0);
        chk("clrp_count", 32'(count), 32'd0);
        clr = 1'b0;
        repeat (4) step();
        chk("clrp_served", 32'(count), 32'd2);
        chk("clrp_req",    32'(req),   32'd0);

        // en=0 freezes grants
        en = 1'b0;
        req[0] = 1'b1;
        dir[0] = 1'b1;
        repeat (3) begin
            step();
            chk("en0_ack",   32'(ack),   32'd0);
            chk("en0_count", 32'(count), 32'd2);
        end
        en = 1'b1;
        step();
        chk("en1_ack",   32'(ack),   32'b0001);
        chk("en1_count", 32'(count), 32'd3);

        // Reset in the middle of a GRANT cycle
        do_req(1, 1'b1);
        do_req(2, 1'b1);
        chk("pre_count", 32'(count), 32'd5);
        step();
        auto_drop = 1'b0;
        req = 4'hF;
        dir = 4'hF;
        step();
        chk("mid_ack", 32'(ack), 32'b1000);
        #2 rst = 1'b1;
        #1;
        chk("arst_pulse", 32'({ack, nack, change}), 32'd0);
        chk("arst_count", 32'(count), 32'd0);
        chk("arst_empty", 32'(empty), 32'd1);
        chk("arst_state", 32'(state), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        step();
        chk("post_ack",   32'(ack),   32'b0001);
        chk("post_count", 32'(count), 32'd1);
        step();
        chk("post_ack2",  32'(ack),   32'b0010);
        chk("post_count2", 32'(count), 32'd2);
        req = '0;
        auto_drop = 1'b1;
        repeat (3) step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
